// File: rtl/cdb_arbiter.sv
// cdb_arbiter: completion arbiter between functional units and the CDB/ROB.
// Each FU source has one holding register. Up to NUM_PORTS held results are
// broadcast per cycle, and starved entries are promoted ahead of normal
// requests. A squash drops every held result.
// Optional feature macro: CDB_ROTATE_PRIORITY_EN. When it is defined, priority
// rotates from rr_ptr. When it is undefined, priority is fixed with index 0
// highest, and starvation promotion still applies.

`ifndef NUM_FU_ALU
`define NUM_FU_ALU 2
`endif
`ifndef NUM_FU_MULT
`define NUM_FU_MULT 1
`endif
`ifndef NUM_FU_LOAD
`define NUM_FU_LOAD 1
`endif
`ifndef N
`define N 2
`endif

package cdb_arbiter_pkg;
    typedef struct packed {
        logic [5:0]  dest_prn;
        logic [31:0] value;
    } CDB_PACKET;

    typedef struct packed {
        logic [4:0]  robn;
        logic        executed;
        logic        branch_taken;
        logic [31:0] target_addr;
    } FU_ROB_PACKET;
endpackage

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC      = `NUM_FU_ALU + `NUM_FU_MULT + `NUM_FU_LOAD,
    parameter int NUM_PORTS    = `N,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               squash,
    input  logic [NUM_SRC-1:0] src_valid,
    input  logic [NUM_SRC-1:0] src_rob_only,
    input  CDB_PACKET          src_cdb [NUM_SRC],
    input  FU_ROB_PACKET       src_rob [NUM_SRC],
    output logic [NUM_SRC-1:0] src_ready,
    output CDB_PACKET          cdb_out [NUM_PORTS],
    output FU_ROB_PACKET       fu_rob_out [NUM_PORTS],
    output logic [NUM_SRC-1:0] grant_debug
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [PTR_W:0]   SRC_W = (PTR_W + 1)'(NUM_SRC);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [NUM_SRC-1:0] held_valid;
    logic [NUM_SRC-1:0] held_rob_only;
    CDB_PACKET          held_cdb [NUM_SRC];
    FU_ROB_PACKET       held_rob [NUM_SRC];
    logic [CNT_W-1:0]   wait_cnt [NUM_SRC];

    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] starved;
    logic [NUM_SRC-1:0] granted;
    logic [NUM_SRC-1:0] capture;
    logic [PTR_W-1:0]   base;
    logic [PTR_W-1:0]   gidx;
    logic [PTR_W-1:0]   pidx;
    int                 n_grant;
    int                 n_port;

    // Map a priority offset to a source index, wrapping at NUM_SRC.
    function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] start, input int off);
        logic [PTR_W:0] sum;
        sum = {1'b0, start} + (PTR_W + 1)'(off);
        if (sum >= SRC_W) sum = sum - SRC_W;
        return sum[PTR_W-1:0];
    endfunction

`ifdef CDB_ROTATE_PRIORITY_EN
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_next;
    int               last_off;
    assign base    = rr_ptr;
    assign rr_next = rot_idx(rr_ptr, last_off + 1);
`else
    assign base = '0;
`endif

    assign req       = held_valid & ~{NUM_SRC{squash}};
    assign src_ready = (~held_valid | granted) & ~{NUM_SRC{squash}};
    assign capture   = src_valid & src_ready;
    assign grant_debug = granted;

    // Flag requesters that have waited long enough to jump the priority queue.
    always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            starved[i] = req[i] && (wait_cnt[i] == LIMIT);
        end
    end

    // Select up to NUM_PORTS winners: starved sources first, then everyone else, both in priority order.
    always_comb begin
        granted = '0;
        n_grant = 0;
        gidx    = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            gidx = rot_idx(base, j);
            if (starved[gidx] && n_grant < NUM_PORTS) begin
                granted[gidx] = 1'b1;
                n_grant++;
            end
        end
        for (int j = 0; j < NUM_SRC; j++) begin
            gidx = rot_idx(base, j);
            if (req[gidx] && !granted[gidx] && n_grant < NUM_PORTS) begin
                granted[gidx] = 1'b1;
                n_grant++;
            end
        end
    end

    // Pack winners onto ports in priority order; idle ports stay all-zero.
    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            cdb_out[k]    = '0;
            fu_rob_out[k] = '0;
        end
        n_port = 0;
        pidx   = '0;
`ifdef CDB_ROTATE_PRIORITY_EN
        last_off = 0;
`endif
        for (int j = 0; j < NUM_SRC; j++) begin
            pidx = rot_idx(base, j);
            if (granted[pidx]) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    if (k == n_port) begin
                        cdb_out[k]             = held_rob_only[pidx] ? '0 : held_cdb[pidx];
                        fu_rob_out[k]          = held_rob[pidx];
                        fu_rob_out[k].executed = 1'b1;
                    end
                end
`ifdef CDB_ROTATE_PRIORITY_EN
                last_off = j;
`endif
                n_port++;
            end
        end
    end

    // Track occupancy and age of each holding register; reset and squash empty them all.
    always_ff @(posedge clock) begin
        if (reset || squash) begin
            held_valid <= '0;
            for (int i = 0; i < NUM_SRC; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (capture[i]) begin
                    held_valid[i] <= 1'b1;
                    wait_cnt[i]   <= '0;
                end else if (granted[i]) begin
                    held_valid[i] <= 1'b0;
                    wait_cnt[i]   <= '0;
                end else if (held_valid[i] && wait_cnt[i] != LIMIT) begin
                    wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Load result payloads only when a source is accepted, so held data is never overwritten.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (capture[i]) begin
                held_rob_only[i] <= src_rob_only[i];
                held_cdb[i]      <= src_cdb[i];
                held_rob[i]      <= src_rob[i];
            end
        end
    end

`ifdef CDB_ROTATE_PRIORITY_EN
    // Move the rotating pointer just past the last winner whenever anything is granted.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (|granted) begin
            rr_ptr <= rr_next;
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed self-checking bench for cdb_arbiter.
// Instance dut_a has 4 sources and 2 ports. Instance dut_b has 4 sources and 1 port.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic squash = 1'b0;

    logic [3:0]   a_valid, a_rob_only, a_ready, a_grant;
    CDB_PACKET    a_cdb [4];
    FU_ROB_PACKET a_rob [4];
    CDB_PACKET    a_cdb_out [2];
    FU_ROB_PACKET a_rob_out [2];

    logic [3:0]   b_valid, b_rob_only, b_ready, b_grant;
    CDB_PACKET    b_cdb [4];
    FU_ROB_PACKET b_rob [4];
    CDB_PACKET    b_cdb_out [1];
    FU_ROB_PACKET b_rob_out [1];

    int checks = 0;
    int errors = 0;

    cdb_arbiter #(.NUM_SRC(4), .NUM_PORTS(2), .STARVE_LIMIT(4)) dut_a (
        .clock(clock), .reset(reset), .squash(squash),
        .src_valid(a_valid), .src_rob_only(a_rob_only),
        .src_cdb(a_cdb), .src_rob(a_rob), .src_ready(a_ready),
        .cdb_out(a_cdb_out), .fu_rob_out(a_rob_out), .grant_debug(a_grant)
    );

    cdb_arbiter #(.NUM_SRC(4), .NUM_PORTS(1), .STARVE_LIMIT(4)) dut_b (
        .clock(clock), .reset(reset), .squash(1'b0),
        .src_valid(b_valid), .src_rob_only(b_rob_only),
        .src_cdb(b_cdb), .src_rob(b_rob), .src_ready(b_ready),
        .cdb_out(b_cdb_out), .fu_rob_out(b_rob_out), .grant_debug(b_grant)
    );

    always #5 clock = ~clock;

    // Compare one observed value against its expected value and count the result.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Present a finished result on source idx of dut_a.
    task automatic applyStimulus(input int idx, input logic [31:0] value, input logic [5:0] prn,
                                 input logic [4:0] robn, input logic rob_only);
        a_valid[idx]    = 1'b1;
        a_rob_only[idx] = rob_only;
        a_cdb[idx]      = '{dest_prn: prn, value: value};
        a_rob[idx]      = '{robn: robn, executed: 1'b0, branch_taken: 1'b0, target_addr: 32'h0};
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        a_valid = '0; a_rob_only = '0;
        b_valid = '0; b_rob_only = '0;
        for (int i = 0; i < 4; i++) begin
            a_cdb[i] = '0; a_rob[i] = '0; b_cdb[i] = '0; b_rob[i] = '0;
        end
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        checkOutput("rst_ready", 64'(a_ready), 64'hF);
        checkOutput("rst_grant", 64'(a_grant), 64'h0);
        checkOutput("rst_cdb0", 64'(a_cdb_out[0]), 64'h0);
        checkOutput("rst_rob1", 64'(a_rob_out[1]), 64'h0);

        // All four sources at once: two per cycle in index order
        for (int i = 0; i < 4; i++) applyStimulus(i, 32'(10 + i), 6'(i + 1), 5'(i + 1), 1'b0);
        tick();
        a_valid = '0;
        checkOutput("t1_c0_val0", 64'(a_cdb_out[0].value), 64'd10);
        checkOutput("t1_c0_val1", 64'(a_cdb_out[1].value), 64'd11);
        checkOutput("t1_c0_prn1", 64'(a_cdb_out[1].dest_prn), 64'd2);
        checkOutput("t1_c0_rob0", 64'(a_rob_out[0]), 64'({5'd1, 1'b1, 1'b0, 32'h0}));
        checkOutput("t1_c0_ready", 64'(a_ready), 64'h3);
        checkOutput("t1_c0_grant", 64'(a_grant), 64'h3);
        tick();
        checkOutput("t1_c1_val0", 64'(a_cdb_out[0].value), 64'd12);
        checkOutput("t1_c1_val1", 64'(a_cdb_out[1].value), 64'd13);
        checkOutput("t1_c1_grant", 64'(a_grant), 64'hC);
        checkOutput("t1_c1_ready", 64'(a_ready), 64'hF);
        tick();
        checkOutput("t1_idle_grant", 64'(a_grant), 64'h0);
        checkOutput("t1_idle_exec", 64'(a_rob_out[0].executed), 64'h0);

        // ROB-only completion: no register broadcast
        applyStimulus(1, 32'h99, 6'd7, 5'd5, 1'b1);
        a_rob[1].branch_taken = 1'b1;
        a_rob[1].target_addr  = 32'h40;
        tick();
        a_valid = '0;
        checkOutput("t2_rob0", 64'(a_rob_out[0]), 64'({5'd5, 1'b1, 1'b1, 32'h40}));
        checkOutput("t2_cdb0", 64'(a_cdb_out[0]), 64'h0);
        checkOutput("t2_rob1_exec", 64'(a_rob_out[1].executed), 64'h0);
        checkOutput("t2_grant", 64'(a_grant), 64'h2);
        tick();

        // Squash with three held entries
        for (int i = 0; i < 3; i++) applyStimulus(i, 32'(20 + i), 6'(i + 1), 5'(i + 1), 1'b0);
        tick();
        a_valid = '0;
        squash = 1'b1;
        #1;
        checkOutput("t4_sq_ready", 64'(a_ready), 64'h0);
        checkOutput("t4_sq_grant", 64'(a_grant), 64'h0);
        checkOutput("t4_sq_cdb0", 64'(a_cdb_out[0]), 64'h0);
        checkOutput("t4_sq_rob0", 64'(a_rob_out[0]), 64'h0);
        checkOutput("t4_sq_rob1", 64'(a_rob_out[1]), 64'h0);
        tick();
        squash = 1'b0;
        #1;
        checkOutput("t4_post_ready", 64'(a_ready), 64'hF);
        checkOutput("t4_post_grant", 64'(a_grant), 64'h0);

        // Return to a known priority start
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Losing source keeps its old value; the new one waits for the grant
        applyStimulus(0, 32'h21, 6'd1, 5'd1, 1'b0);
        applyStimulus(1, 32'h22, 6'd2, 5'd2, 1'b0);
        applyStimulus(2, 32'h55, 6'd3, 5'd3, 1'b0);
        tick();
        a_valid = '0;
        applyStimulus(2, 32'h77, 6'd4, 5'd4, 1'b0);
        #1;
        checkOutput("t5_a_ready2", 64'(a_ready[2]), 64'h0);
        checkOutput("t5_a_val0", 64'(a_cdb_out[0].value), 64'h21);
        checkOutput("t5_a_val1", 64'(a_cdb_out[1].value), 64'h22);
        tick();
        checkOutput("t5_b_val0", 64'(a_cdb_out[0].value), 64'h55);
        checkOutput("t5_b_ready2", 64'(a_ready[2]), 64'h1);
        checkOutput("t5_b_grant", 64'(a_grant), 64'h4);
        checkOutput("t5_b_rob1_exec", 64'(a_rob_out[1].executed), 64'h0);
        tick();
        a_valid = '0;
        checkOutput("t5_c_val0", 64'(a_cdb_out[0].value), 64'h77);
        checkOutput("t5_c_grant", 64'(a_grant), 64'h4);
        tick();
        checkOutput("t5_d_grant", 64'(a_grant), 64'h0);

        // Reset together with squash while four entries are held
        for (int i = 0; i < 4; i++) applyStimulus(i, 32'(48 + i), 6'(i + 1), 5'(i + 1), 1'b0);
        tick();
        a_valid = '0;
        checkOutput("t6_pre_grant", 64'(a_grant), 64'h3);
        reset = 1'b1;
        squash = 1'b1;
        tick();
        reset = 1'b0;
        squash = 1'b0;
        #1;
        checkOutput("t6_ready", 64'(a_ready), 64'hF);
        checkOutput("t6_grant", 64'(a_grant), 64'h0);
        checkOutput("t6_cdb0", 64'(a_cdb_out[0]), 64'h0);
        checkOutput("t6_rob0_exec", 64'(a_rob_out[0].executed), 64'h0);
        tick();
        checkOutput("t6_stale_grant", 64'(a_grant), 64'h0);
        checkOutput("t6_stale_cdb1", 64'(a_cdb_out[1]), 64'h0);

`ifndef CDB_ROTATE_PRIORITY_EN
        // Single port, fixed priority: src3 is promoted past a busy src0
        b_valid[0] = 1'b1;
        b_cdb[0]   = '{dest_prn: 6'd1, value: 32'h100};
        b_valid[3] = 1'b1;
        b_cdb[3]   = '{dest_prn: 6'd4, value: 32'h333};
        tick();
        b_valid[3] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("t3_wait%0d_grant", c), 64'(b_grant), 64'h1);
            tick();
        end
        checkOutput("t3_promo_grant", 64'(b_grant), 64'h8);
        checkOutput("t3_promo_val", 64'(b_cdb_out[0].value), 64'h333);
        checkOutput("t3_promo_ready", 64'(b_ready), 64'hE);
        tick();
        checkOutput("t3_after_grant", 64'(b_grant), 64'h1);
        checkOutput("t3_after_val", 64'(b_cdb_out[0].value), 64'h100);
        b_valid = '0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
